// File: rtl/cpu_defs.sv
// Shared definitions for the EX-stage multiply/divide unit: func codes,
// datapath width and FSM state encoding.
package cpu_defs;

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W);

  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

  function automatic logic is_muldiv_func(input logic [5:0] f);
    case (f)
      FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic is_hilo_func(input logic [5:0] f);
    case (f)
      FUNC_MFHI, FUNC_MTHI, FUNC_MFLO, FUNC_MTLO: return 1'b1;
      default:                                    return is_muldiv_func(f);
    endcase
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative unsigned core: shift-add multiply or restoring divide, one bit per
// step. For divide the result is {remainder, quotient}.
module muldiv_datapath
  import cpu_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DATA_W-1:0]     a_mag,
  input  logic [DATA_W-1:0]     b_mag,
  output logic [2*DATA_W-1:0]   result
);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic                div_q, div_d;
  logic [DATA_W:0]     add_s, rem_sh_s, trial_s;

  // acc holds {partial, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    div_d    = div_q;
    add_s    = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
    rem_sh_s = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    trial_s  = rem_sh_s - {1'b0, opnd_q};
    if (start) begin
      div_d  = is_div;
      opnd_d = is_div ? b_mag : a_mag;
      acc_d  = {{DATA_W{1'b0}}, (is_div ? a_mag : b_mag)};
    end else if (step) begin
      if (div_q) begin
        if (!trial_s[DATA_W]) begin
          acc_d = {trial_s[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        end else begin
          acc_d = {rem_sh_s[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        end
      end else begin
        acc_d = {add_s, acc_q[DATA_W-1:1]};
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
    end
  end

  assign result = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit with HI/LO registers, sign
// fix-up and a stall towards hazard control for HI/LO accesses while busy.
module ex_muldiv_unit
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [5:0]        i_func,
  input  logic [DATA_W-1:0] i_BusA,
  input  logic [DATA_W-1:0] i_BusB,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_stall,
  output logic              o_done
);

  muldiv_state_t       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, araw_q, araw_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, div0_q, div0_d;

  logic                start_s, is_div_s, signed_s, a_neg_s, b_neg_s;
  logic [DATA_W-1:0]   a_mag_s, b_mag_s, quot_s, rem_s;
  logic [2*DATA_W-1:0] res_s, prod_s;

  always_comb begin
    start_s  = i_valid & (state_q == ST_IDLE) & is_muldiv_func(i_func);
    is_div_s = i_func[1];
    signed_s = ~i_func[0];
    a_neg_s  = signed_s & i_BusA[DATA_W-1];
    b_neg_s  = signed_s & i_BusB[DATA_W-1];
    a_mag_s  = a_neg_s ? -i_BusA : i_BusA;
    b_mag_s  = b_neg_s ? -i_BusB : i_BusB;
    o_stall  = (state_q != ST_IDLE) & i_valid & is_hilo_func(i_func);
    if (i_valid) begin
      case (i_func)
        FUNC_MFHI: o_rdata = hi_q;
        FUNC_MFLO: o_rdata = lo_q;
        default:   o_rdata = '0;
      endcase
    end else begin
      o_rdata = '0;
    end
  end

  muldiv_datapath u_datapath (
    .clk    (clk),
    .rst    (rst),
    .start  (start_s),
    .step   (state_q == ST_CALC),
    .is_div (is_div_s),
    .a_mag  (a_mag_s),
    .b_mag  (b_mag_s),
    .result (res_s)
  );

  // Sign correction applied on the FIX edge; divide by zero overrides the core result
  always_comb begin
    prod_s = neg_lo_q ? -res_s : res_s;
    quot_s = neg_lo_q ? -res_s[DATA_W-1:0] : res_s[DATA_W-1:0];
    rem_s  = neg_hi_q ? -res_s[2*DATA_W-1:DATA_W] : res_s[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    araw_d   = araw_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid && i_func == FUNC_MTHI) begin
          hi_d = i_BusA;
        end else if (i_valid && i_func == FUNC_MTLO) begin
          lo_d = i_BusA;
        end else if (start_s) begin
          state_d  = ST_CALC;
          cnt_d    = '0;
          div_d    = is_div_s;
          neg_lo_d = a_neg_s ^ b_neg_s;
          neg_hi_d = a_neg_s;
          div0_d   = is_div_s & (i_BusB == {DATA_W{1'b0}});
          araw_d   = i_BusA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (!div_q) begin
          hi_d = prod_s[2*DATA_W-1:DATA_W];
          lo_d = prod_s[DATA_W-1:0];
        end else if (div0_q) begin
          hi_d = araw_q;
          lo_d = {DATA_W{1'b1}};
        end else begin
          hi_d = rem_s;
          lo_d = quot_s;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      araw_q   <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      araw_q   <= araw_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: state changes on negedge, inputs driven
// and outputs sampled just after posedge.
module tb_ex_muldiv_unit;
  import cpu_defs::*;

  localparam logic [5:0] FUNC_ADD = 6'b100000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [5:0]  i_func;
  logic [31:0] i_BusA, i_BusB, o_rdata;
  logic        o_busy, o_stall, o_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_func  (i_func),
    .i_BusA  (i_BusA),
    .i_BusB  (i_BusB),
    .o_rdata (o_rdata),
    .o_busy  (o_busy),
    .o_stall (o_stall),
    .o_done  (o_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    i_valid = v;
    i_func  = f;
    i_BusA  = a;
    i_BusB  = b;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    drive(1'b1, FUNC_MFHI, 32'h0, 32'h0);
    #1 check_eq({tag, " HI"}, {32'h0, o_rdata}, {32'h0, ehi});
    drive(1'b1, FUNC_MFLO, 32'h0, 32'h0);
    #1 check_eq({tag, " LO"}, {32'h0, o_rdata}, {32'h0, elo});
    drive(1'b0, 6'h0, 32'h0, 32'h0);
  endtask

  // Issue one mul/div, keep an unrelated ADD in EX while busy, then check timing and HI/LO
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int busy_n  = 0;
    int done_n  = 0;
    int stall_n = 0;
    int done_at = -1;
    @(posedge clk); drive(1'b1, f, a, b);
    @(posedge clk); drive(1'b1, FUNC_ADD, 32'h1, 32'h2);
    for (int k = 0; k < 36; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      if (o_busy)  busy_n++;
      if (o_stall) stall_n++;
      if (o_done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
    end
    drive(1'b0, 6'h0, 32'h0, 32'h0);
    check_eq({tag, " busy cycles"}, 64'(busy_n), 64'd33);
    check_eq({tag, " done count"}, 64'(done_n), 64'd1);
    check_eq({tag, " done timing"}, 64'(done_at), 64'd33);
    check_eq({tag, " add stall"}, 64'(stall_n), 64'd0);
    read_hilo(tag, ehi, elo);
  endtask

  initial begin
    int k;
    int bad;
    rst = 1'b1;
    drive(1'b1, FUNC_MFHI, 32'h0, 32'h0);
    #1;
    check_eq("reset busy", {63'h0, o_busy}, 64'h0);
    check_eq("reset done", {63'h0, o_done}, 64'h0);
    check_eq("reset stall", {63'h0, o_stall}, 64'h0);
    check_eq("reset rdata", {32'h0, o_rdata}, 64'h0);
    @(posedge clk); rst = 1'b0;
    drive(1'b0, 6'h0, 32'h0, 32'h0);

    run_op("multu max", FUNC_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult neg",  FUNC_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("div -7/2",  FUNC_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div 7/-2",  FUNC_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu 100/7", FUNC_DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
    run_op("divu by 0", FUNC_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
    run_op("div ovf",   FUNC_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MFLO right behind MULT 7 x -3 stalls until HI/LO are written
    @(posedge clk); drive(1'b1, FUNC_MULT, 32'd7, 32'hFFFFFFFD);
    @(posedge clk); drive(1'b1, FUNC_MFLO, 32'h0, 32'h0);
    k = 0;
    #1;
    while (o_stall && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("mflo stall cycles", 64'(k), 64'd33);
    check_eq("mflo after stall", {32'h0, o_rdata}, {32'h0, 32'hFFFFFFEB});
    read_hilo("mult 7*-3", 32'hFFFFFFFF, 32'hFFFFFFEB);

    @(posedge clk); drive(1'b1, FUNC_MTHI, 32'hA5A5A5A5, 32'h0);
    @(posedge clk); read_hilo("mthi", 32'hA5A5A5A5, 32'hFFFFFFEB);
    @(posedge clk); drive(1'b1, FUNC_MTLO, 32'h5A5A5A5A, 32'h0);
    @(posedge clk); read_hilo("mtlo", 32'hA5A5A5A5, 32'h5A5A5A5A);

    // Reset in the middle of CALC abandons the operation
    @(posedge clk); drive(1'b1, FUNC_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk); drive(1'b0, 6'h0, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    #1 check_eq("busy mid calc", {63'h0, o_busy}, 64'h1);
    rst = 1'b1;
    #1;
    check_eq("rst busy", {63'h0, o_busy}, 64'h0);
    check_eq("rst done", {63'h0, o_done}, 64'h0);
    read_hilo("rst", 32'h0, 32'h0);
    bad = 0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      if (o_busy || o_done) bad++;
    end
    check_eq("rst quiet", 64'(bad), 64'd0);
    @(posedge clk); rst = 1'b0;
    run_op("multu 3*5", FUNC_MULTU, 32'd3, 32'd5, 32'h00000000, 32'h0000000F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
EX-stage multi-cycle multiply/divide unit with architectural HI/LO registers. It sits downstream of the ID/EX pipeline register and consumes its outputs: func, BusA and BusB for R-type instructions.
- MULT/MULTU/DIV/DIVU run in the background, iteratively.
- MFHI/MFLO/MTHI/MTLO access HI/LO.
- A HI/LO access while an operation is in flight raises a stall to hazard control.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.

Ports:
clk  in  1  pipeline clock; all state changes on negedge, matching the pipeline registers
rst  in  1  asynchronous, active-high reset
i_valid  in  1  EX holds a real R-type instruction (0 for bubbles)
i_func  in  6  func field from ID/EX
i_BusA  in  32  rs operand (dividend / multiplicand / MTxx source)
i_BusB  in  32  rt operand (divisor / multiplier)
o_rdata  out  32  MFHI→HI, MFLO→LO, otherwise 0; combinational
o_busy  out  1  operation in flight
o_stall  out  1  freeze IF/ID/EX and bubble MEM; combinational
o_done  out  1  one-cycle pulse when HI/LO are updated by mul/div

Behaviour:
- Reset: asynchronous on rst high.
  - State returns to IDLE; HI, LO, counter and datapath registers go to 0.
  - o_busy=0, o_done=0; o_stall and o_rdata evaluate to 0.
  - A reset mid-operation abandons the operation.
- func decode:
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
  - Everything else is ignored.
  - Every decode is qualified by i_valid.
- Define hilo_op = i_valid & (func is any of the eight above).
- o_stall = (state != IDLE) & hilo_op. Non-HI/LO instructions flow freely while busy.
- States: IDLE, CALC, FIX.
- IDLE:
  - MTHI/MTLO: write i_BusA into HI/LO on the edge.
  - mul/div start: latch the operands on the edge (edge t0), then go to CALC.
    - Signed ops latch magnitudes and record result signs.
  - While stalled, the instruction is held and is accepted on the first edge after the unit reaches IDLE.
- CALC:
  - MULT/MULTU: shift-add, one bit per edge.
  - DIV/DIVU: restoring division, one quotient bit per edge.
  - A 5-bit counter runs on edges t1..t32; after count 31, go to FIX.
- FIX (edge t33):
  - Apply sign correction and write HI/LO.
  - o_done=1 for the cycle following t33; return to IDLE.
- o_busy=1 from after t0 until after t33.
- Total latency: 33 edges from acceptance to HI/LO valid. An MFHI stalled behind the op reads the new value in the cycle after t33.
- Multiply: the full 64-bit product goes to {HI,LO}. Signed results use two's-complement negation of the 64-bit magnitude when the operand signs differ.
- Divide: LO = quotient, HI = remainder.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A). This gives truncation toward zero.
- Divide by zero: LO = 0xFFFFFFFF, HI = dividend (raw i_BusA). Still takes 33 edges.
- Signed DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO while busy stall like any HI/LO op. There is no write hazard into the in-flight result.
- Stall and bubble: while o_stall=1, the ID/EX register must hold; the unit never re-latches a held mul/div.

Decomposition:
- Shared package (cpu_defs):
  - func constants FUNC_MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO
  - state encoding typedef muldiv_state_t
  - DATA_W
- One sub-module is natural: muldiv_datapath.
  - Holds the iterative shift-add/restoring-divide core.
  - Inputs: start, is_div, magnitudes.
  - Output: 64-bit magnitude result.
- The top keeps the FSM, sign fix-up, HI/LO and stall logic.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 33 edges HI=0xFFFFFFFE, LO=0x00000001; o_done one cycle; o_busy high exactly 33 cycles.
- MULT A=0xFFFFFFFE, B=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. A following ADD proceeds with o_stall=0.
- DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=100, B=7 → LO=0x0000000E, HI=0x00000002.
- DIVU A=0x12345678, B=0 → LO=0xFFFFFFFF, HI=0x12345678. Signed DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MULT then MFLO issued one cycle later → o_stall=1 until after t33, then o_rdata equals the new LO. MTHI 0xA5A5A5A5 in IDLE → HI updated next edge; MFHI returns 0xA5A5A5A5.
- Assert rst mid-CALC (count 10) → immediately o_busy=0, HI=LO=0, no o_done. A new MULTU 3×5 afterwards gives LO=15, HI=0.
